// File: rtl/graphics_pixel_writer_if.sv
// Pixel stream / frame-buffer write bundle.
// Shared pixel type plus the ST sink and MM master signal group.
package gpw_pkg;
   localparam int COORD_DATA_WIDTH = 12;
   localparam int COLOR_DATA_WIDTH = 16;

   typedef struct packed {
      logic [COORD_DATA_WIDTH-1:0] x;
      logic [COORD_DATA_WIDTH-1:0] y;
      logic [COLOR_DATA_WIDTH-1:0] color;
   } pixel_t;
endpackage

interface graphics_pixel_writer_if #(
   parameter int ADDR_WIDTH = 32
);
   import gpw_pkg::*;

   pixel_t                      st_data;
   logic                        st_valid;
   logic                        st_ready;
   logic [ADDR_WIDTH-1:0]       mm_address;
   logic [COLOR_DATA_WIDTH-1:0] mm_writedata;
   logic                        mm_write;
   logic                        mm_waitrequest;

   // writer side
   modport slave (
      input  st_data, st_valid, mm_waitrequest,
      output st_ready, mm_address, mm_writedata, mm_write
   );

   // engine / memory side
   modport master (
      output st_data, st_valid, mm_waitrequest,
      input  st_ready, mm_address, mm_writedata, mm_write
   );
endinterface

// File: rtl/graphics_pixel_writer.sv
// Pixel stream sink: FIFO, off-screen clip, address map.
// One frame-buffer write per visible pixel, in order.
module graphics_pixel_writer
   import gpw_pkg::*;
#(
   parameter int                    H_RES      = 640,
   parameter int                    V_RES      = 480,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] FB_BASE    = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clken,
   graphics_pixel_writer_if.slave   bus,
   output logic                     idle,
   output logic [15:0]              drop_count,
   input  logic                     drop_clear
);

   localparam int BPP = (COLOR_DATA_WIDTH + 7) / 8;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   localparam logic [CW-1:0] RDY_MAX = CW'(FIFO_DEPTH - 2);
   localparam logic [COORD_DATA_WIDTH-1:0] H_LIM = COORD_DATA_WIDTH'(H_RES);
   localparam logic [COORD_DATA_WIDTH-1:0] V_LIM = COORD_DATA_WIDTH'(V_RES);

   pixel_t                      mem_q [FIFO_DEPTH];
   pixel_t                      mem_d [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        st_ready_q, st_ready_d;
   logic                        mm_write_q, mm_write_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [COLOR_DATA_WIDTH-1:0] data_q, data_d;
   logic                        idle_q, idle_d;
   logic [15:0]                 drop_q, drop_d;

   logic                        on_screen;
   logic                        accept;
   logic                        push;
   logic                        pop;
   logic                        out_free;
   pixel_t                      head;
   logic [ADDR_WIDTH-1:0]       pix_addr;

   assign bus.st_ready     = st_ready_q & clken;
   assign bus.mm_write     = mm_write_q;
   assign bus.mm_address   = addr_q;
   assign bus.mm_writedata = data_q;
   assign idle             = idle_q;
   assign drop_count       = drop_q;

   // Handshake decode: accept, clip, push and pop strobes
   always_comb begin
      on_screen = (bus.st_data.x < H_LIM) && (bus.st_data.y < V_LIM);
      accept    = bus.st_valid && st_ready_q && clken;
      push      = accept && on_screen;
      out_free  = !mm_write_q || !bus.mm_waitrequest;
      pop       = out_free && (cnt_q != '0) && clken;
      head      = mem_q[rd_ptr_q];
      pix_addr  = FB_BASE
                + (ADDR_WIDTH'(head.y) * ADDR_WIDTH'(H_RES)
                +  ADDR_WIDTH'(head.x)) * ADDR_WIDTH'(BPP);
   end

   // FIFO storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.st_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Output register, ready/idle status and drop counter
   always_comb begin
      mm_write_d = mm_write_q;
      addr_d     = addr_q;
      data_d     = data_q;
      if (pop) begin
         mm_write_d = 1'b1;
         addr_d     = pix_addr;
         data_d     = head.color;
      end else if (mm_write_q && !bus.mm_waitrequest) begin
         mm_write_d = 1'b0;
      end
      st_ready_d = (cnt_d <= RDY_MAX);
      idle_d     = (cnt_d == '0) && !mm_write_d && !accept;
      drop_d     = drop_q;
      if (drop_clear) begin
         drop_d = '0;
      end else if (accept && !on_screen && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   // State registers; reset drops queued pixels and any pending write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         st_ready_q <= 1'b0;
         mm_write_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         idle_q     <= 1'b1;
         drop_q     <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         st_ready_q <= st_ready_d;
         mm_write_q <= mm_write_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         idle_q     <= idle_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_graphics_pixel_writer.sv
// Bench for graphics_pixel_writer.
// Directed scenarios plus a random stream against a queue model.
module tb_graphics_pixel_writer;
   import gpw_pkg::*;

   localparam int DEPTH = 4;
   localparam int HR    = 640;
   localparam int VR    = 480;
   localparam int BPP   = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clken;
   logic        drop_clear;
   logic        idle;
   logic [15:0] drop_count;

   graphics_pixel_writer_if #(.ADDR_WIDTH(32)) bus ();

   graphics_pixel_writer #(
      .H_RES(HR), .V_RES(VR), .ADDR_WIDTH(32),
      .FB_BASE(32'h0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .bus(bus), .idle(idle),
      .drop_count(drop_count), .drop_clear(drop_clear)
   );

   always #5 clk = ~clk;

   wr_t         sb[$];
   pixel_t      src[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_wr, n_on;
   int          first_acc, first_wr, first_done, last_done;
   int          vprob = 100;
   int          wr_mode = 0;
   int          drop_m = 0;
   bit          rdy_ok = 0;
   bit          hold_prev = 0;
   bit          rnd_mode = 0;
   logic [31:0] prev_addr;
   logic [15:0] prev_data;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic pixel_t mk(int x, int y, int c);
      pixel_t p;
      p.x     = 12'(x);
      p.y     = 12'(y);
      p.color = 16'(c);
      return p;
   endfunction

   function automatic bit visible(pixel_t p);
      return (int'(p.x) < HR) && (int'(p.y) < VR);
   endfunction

   function automatic logic [31:0] exp_addr(pixel_t p);
      return 32'((int'(p.y) * HR + int'(p.x)) * BPP);
   endfunction

   task automatic kick();
      if (!bus.st_valid && src.size() > 0) begin
         bus.st_valid = 1'b1;
         bus.st_data  = src[0];
      end
   endtask

   // one clock: observe at negedge+1, update model, drive next inputs
   task automatic step();
      logic   acc, done;
      int     fcnt;
      wr_t    w;
      pixel_t p;
      #1;
      fcnt = sb.size() - (bus.mm_write ? 1 : 0);
      if (rdy_ok) begin
         chk("st_ready", bus.st_ready, clken && (fcnt <= DEPTH - 2));
         if (sb.size() > 0) chk("idle_busy", idle, 0);
      end
      chk("drop_count", drop_count, drop_m);
      if (hold_prev) begin
         chk("hold_wr", bus.mm_write, 1);
         chk("hold_addr", bus.mm_address, prev_addr);
         chk("hold_data", bus.mm_writedata, prev_data);
      end
      acc  = bus.st_valid && bus.st_ready && clken;
      done = bus.mm_write && !bus.mm_waitrequest;
      if (bus.mm_write && first_wr < 0) first_wr = cyc;
      if (done) begin
         n_wr++;
         if (first_done < 0) first_done = cyc;
         last_done = cyc;
         if (sb.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            w = sb.pop_front();
            chk("wr_addr", bus.mm_address, w.addr);
            chk("wr_data", bus.mm_writedata, w.data);
         end
      end
      if (acc) begin
         if (first_acc < 0) first_acc = cyc;
         p = src.pop_front();
         if (visible(p)) begin
            w.addr = exp_addr(p);
            w.data = p.color;
            sb.push_back(w);
         end else if (drop_m < 65535) begin
            drop_m++;
         end
      end
      if (drop_clear) drop_m = 0;
      hold_prev = bus.mm_write && bus.mm_waitrequest;
      prev_addr = bus.mm_address;
      prev_data = bus.mm_writedata;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      rdy_ok = reset_n;
      drop_clear = rnd_mode && ($urandom_range(49) == 0);
      if (rnd_mode) clken = ($urandom_range(9) != 0);
      case (wr_mode)
         0:       bus.mm_waitrequest = 1'b0;
         1:       bus.mm_waitrequest = 1'b1;
         default: bus.mm_waitrequest = ($urandom_range(2) == 0);
      endcase
      if (!bus.st_valid || acc) begin
         bus.st_valid = (src.size() > 0) && ($urandom_range(99) < vprob);
         if (bus.st_valid) bus.st_data = src[0];
      end
   endtask

   task automatic drain(int max);
      int k = 0;
      while ((src.size() > 0 || sb.size() > 0 || bus.st_valid)
             && k < max) begin
         step();
         k++;
      end
      if (k >= max) chk("drain_timeout", 1, 0);
   endtask

   task automatic clr_marks();
      n_wr       = 0;
      first_acc  = -1;
      first_wr   = -1;
      first_done = -1;
      last_done  = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.st_valid       = 1'b0;
      bus.st_data        = '0;
      bus.mm_waitrequest = 1'b0;
      clken              = 1'b1;
      drop_clear         = 1'b0;
      reset_n            = 1'b0;
      clr_marks();
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.st_ready, 0);
      chk("rst_write", bus.mm_write, 0);
      chk("rst_addr", bus.mm_address, 0);
      chk("rst_data", bus.mm_writedata, 0);
      chk("rst_idle", idle, 1);
      chk("rst_drop", drop_count, 0);
      reset_n = 1'b1;

      // short line of 7 pixels, no stalls
      for (int i = 0; i < 7; i++) src.push_back(mk(i, 1 + i / 2, 'h3F));
      kick();
      drain(100);
      chk("t1_count", n_wr, 7);
      chk("t1_latency", first_wr - first_acc, 2);
      chk("t1_b2b", last_done - first_done, 6);
      chk("t1_idle", idle, 1);

      // stall the memory for a burst
      clr_marks();
      for (int i = 0; i < 8; i++)
         src.push_back(mk($urandom_range(HR - 1), $urandom_range(VR - 1),
                          $urandom));
      kick();
      bus.mm_waitrequest = 1'b1;
      wr_mode = 1;
      repeat (5) step();
      chk("t2_full_ready", bus.st_ready, 0);
      wr_mode = 0;
      drain(200);
      chk("t2_count", n_wr, 8);

      // clipping and drop counter
      clr_marks();
      src.push_back(mk(640, 0, 'h3F));
      src.push_back(mk(0, 480, 'h3F));
      src.push_back(mk(639, 479, 'h3F));
      kick();
      drain(100);
      chk("t3_count", n_wr, 1);
      chk("t3_drops", drop_count, 2);
      src.push_back(mk(1000, 5, 'h11));
      kick();
      drop_clear = 1'b1;
      step();
      chk("t3_clear_wins", drop_count, 0);

      // clock enable gap with a write pending
      clr_marks();
      for (int i = 0; i < 6; i++) src.push_back(mk(10 + i, 20, 'h100 + i));
      kick();
      bus.mm_waitrequest = 1'b1;
      wr_mode = 1;
      repeat (4) step();
      chk("t4_pending", bus.mm_write, 1);
      clken = 1'b0;
      wr_mode = 0;
      bus.mm_waitrequest = 1'b0;
      step();
      chk("t4_ready_off", bus.st_ready, 0);
      chk("t4_no_pop1", bus.mm_write, 0);
      step();
      chk("t4_no_pop2", bus.mm_write, 0);
      step();
      clken = 1'b1;
      drain(200);
      chk("t4_count", n_wr, 6);

      // reset in the middle of a stalled burst
      clr_marks();
      src.push_back(mk(700, 0, 'h1));
      for (int i = 0; i < 5; i++) src.push_back(mk(i, 7, 'h200 + i));
      kick();
      bus.mm_waitrequest = 1'b1;
      wr_mode = 1;
      repeat (6) step();
      chk("t5_pre_write", bus.mm_write, 1);
      chk("t5_pre_ready", bus.st_ready, 0);
      chk("t5_pre_drop", drop_count, 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_write", bus.mm_write, 0);
      chk("t5_rst_idle", idle, 1);
      chk("t5_rst_ready", bus.st_ready, 0);
      chk("t5_rst_drop", drop_count, 0);
      sb.delete();
      src.delete();
      drop_m = 0;
      hold_prev = 0;
      rdy_ok = 0;
      bus.st_valid = 1'b0;
      bus.mm_waitrequest = 1'b0;
      wr_mode = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) step();
      chk("t5_no_stale", n_wr, 0);
      chk("t5_idle", idle, 1);

      // random stream against the model
      clr_marks();
      n_on = 0;
      for (int i = 0; i < 1000; i++) begin
         pixel_t p;
         p = mk($urandom_range(699), $urandom_range(519), $urandom);
         if (visible(p)) n_on++;
         src.push_back(p);
      end
      rnd_mode = 1;
      vprob = 60;
      wr_mode = 2;
      drain(30000);
      rnd_mode = 0;
      wr_mode = 0;
      clken = 1'b1;
      drop_clear = 1'b0;
      chk("t6_count", n_wr, n_on);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
